// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stability debounce,
// press counter and bounce-abort flag.
`timescale 1ns/1ps
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_raw,
    output logic       button_clean,
    output logic [7:0] press_count,
    output logic       bounce_seen
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_LAST =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync_q1;
    logic                 r_sync_q2;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_clean;
    logic                 w_clean_nxt;
    logic [7:0]           r_presses;
    logic [7:0]           w_presses_nxt;
    logic                 r_bounce;
    logic                 w_bounce_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync_q1 <= 1'b1;
            r_sync_q2 <= 1'b1;
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_clean   <= 1'b1;
            r_presses <= 8'd0;
            r_bounce  <= 1'b0;
        end else begin
            r_sync_q1 <= button_raw;
            r_sync_q2 <= r_sync_q1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clean   <= w_clean_nxt;
            r_presses <= w_presses_nxt;
            r_bounce  <= w_bounce_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_clean_nxt   = r_clean;
        w_presses_nxt = r_presses;
        w_bounce_nxt  = 1'b0;
        unique case (r_state)
            RELEASED: begin
                w_clean_nxt = 1'b1;
                if (!r_sync_q2) begin
                    w_state_nxt = PRESS_PENDING;
                end
            end
            PRESS_PENDING: begin
                if (r_sync_q2) begin
                    w_state_nxt  = RELEASED;
                    w_bounce_nxt = 1'b1;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt   = PRESSED;
                    w_clean_nxt   = 1'b0;
                    w_presses_nxt = r_presses + 8'd1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                w_clean_nxt = 1'b0;
                if (r_sync_q2) begin
                    w_state_nxt = RELEASE_PENDING;
                end
            end
            RELEASE_PENDING: begin
                if (!r_sync_q2) begin
                    w_state_nxt  = PRESSED;
                    w_bounce_nxt = 1'b1;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = RELEASED;
                    w_clean_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_clean_nxt = 1'b1;
            end
        endcase
    end

    assign button_clean = r_clean;
    assign press_count  = r_presses;
    assign bounce_seen  = r_bounce;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: run-length reference model,
// directed scenarios plus randomized bouncing input.
`timescale 1ns/1ps
module tb_button_debouncer;

    localparam int DEB = 4;
    localparam int CW  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       button_raw = 1'b1;
    logic       button_clean;
    logic [7:0] press_count;
    logic       bounce_seen;

    int checks = 0;
    int errors = 0;
    int bounce_tot = 0;

    logic [9:0] exp_q[$];

    // reference model state: delay line plus run length of disagreement
    logic       m_q1 = 1'b1, m_q2 = 1'b1, m_clean = 1'b1, m_b = 1'b0;
    logic [7:0] m_cnt = 8'd0;
    int         m_run = 0;

    button_debouncer #(.DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(CW)) dut (
        .clock(clock),
        .reset(reset),
        .button_raw(button_raw),
        .button_clean(button_clean),
        .press_count(press_count),
        .bounce_seen(bounce_seen)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic raw, input logic rst);
        if (rst) begin
            m_q1 = 1'b1; m_q2 = 1'b1; m_clean = 1'b1;
            m_run = 0; m_cnt = 8'd0; m_b = 1'b0;
        end else begin
            m_b = 1'b0;
            if (m_q2 != m_clean) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_clean = m_q2;
                    m_run = 0;
                    if (!m_q2) m_cnt = m_cnt + 8'd1;
                end
            end else begin
                if (m_run > 0) m_b = 1'b1;
                m_run = 0;
            end
            m_q2 = m_q1;
            m_q1 = raw;
        end
    endtask

    task automatic step(input logic raw, input logic rst);
        @(negedge clock);
        button_raw = raw;
        reset = rst;
        @(posedge clock);
        model_edge(raw, rst);
        exp_q.push_back({m_clean, m_cnt, m_b});
    endtask

    task automatic hold(input logic raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    // edges from the first low sample until button_clean falls
    task automatic latency(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0);
            #1;
            if (!button_clean && n == 0) n = i;
        end
        check(name, n, DEB + 3);
    endtask

    always @(posedge clock) begin
        logic [9:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("button_clean", int'(button_clean), int'(e[9]));
            check("press_count", int'(press_count), int'(e[8:1]));
            check("bounce_seen", int'(bounce_seen), int'(e[0]));
            if (bounce_seen) bounce_tot++;
        end
    end

    initial begin
        int b0;
        logic [7:0] c0;
        logic lvl;

        // reset held with the button already pressed
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        #1;
        check("reset_clean", int'(button_clean), 1);
        check("reset_count", int'(press_count), 0);
        check("reset_bounce", int'(bounce_seen), 0);
        latency("reset_latency");
        check("after_reset_count", int'(press_count), 1);
        hold(1'b1, 10);

        // clean press and release
        latency("press_latency");
        check("press_count1", int'(press_count), 2);
        hold(1'b1, 10);
        #1;
        check("release_clean", int'(button_clean), 1);
        check("release_count", int'(press_count), 2);

        // bounce during press
        b0 = bounce_tot;
        hold(1'b0, 2);
        hold(1'b1, 1);
        hold(1'b0, 12);
        #1;
        check("press_bounce_pulses", bounce_tot - b0, 1);
        check("press_bounce_count", int'(press_count), 3);

        // glitch while pressed
        b0 = bounce_tot;
        hold(1'b1, 3);
        hold(1'b0, 10);
        #1;
        check("glitch_pulses", bounce_tot - b0, 1);
        check("glitch_clean", int'(button_clean), 0);
        check("glitch_count", int'(press_count), 3);
        hold(1'b1, 10);

        // wrap-around over 256 accepted presses
        c0 = press_count;
        for (int i = 0; i < 256; i++) begin
            hold(1'b0, 8);
            hold(1'b1, 8);
        end
        #1;
        check("wrap_count", int'(press_count), int'(c0));

        // reset while a press is pending with counter at 2
        hold(1'b0, 5);
        step(1'b0, 1'b1);
        #1;
        check("midreset_clean", int'(button_clean), 1);
        check("midreset_count", int'(press_count), 0);
        latency("midreset_latency");
        hold(1'b1, 10);

        // randomized bouncing with occasional reset
        lvl = 1'b1;
        for (int s = 0; s < 400; s++) begin
            lvl = ~lvl;
            if ($urandom_range(0, 49) == 0) step(lvl, 1'b1);
            hold(lvl, $urandom_range(1, 9));
        end
        hold(1'b1, 10);

        @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
